// File: rtl/fall_timer_pkg.sv
// rtl/fall_timer_pkg.sv - shared constants for the fall_timer interval timer
//
// Purpose: opcode encodings, status byte bit positions and read-select
//          values shared by the timer top level, its prescaler and users.
// Ports:   none (package).
package fall_timer_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_LDQ   = 4'd1;
  localparam logic [3:0] OP_LDP   = 4'd2;
  localparam logic [3:0] OP_LDC   = 4'd3;
  localparam logic [3:0] OP_START = 4'd4;
  localparam logic [3:0] OP_STOP  = 4'd5;
  localparam logic [3:0] OP_ACK   = 4'd6;
  localparam logic [3:0] OP_RDC   = 4'd7;
  localparam logic [3:0] OP_RDS   = 4'd8;

  localparam int ST_EXPIRED = 0;
  localparam int ST_RUNNING = 1;
  localparam int ST_OVERRUN = 2;
  localparam int ST_BADOP   = 3;

  localparam logic RSEL_COUNT  = 1'b0;
  localparam logic RSEL_STATUS = 1'b1;

  // Status byte: {4'b0, badop, overrun, running, expired}
  function automatic logic [7:0] status_byte(input logic badop, input logic overrun,
                                             input logic running, input logic expired);
    logic [7:0] s;
    s = 8'h00;
    s[ST_BADOP]   = badop;
    s[ST_OVERRUN] = overrun;
    s[ST_RUNNING] = running;
    s[ST_EXPIRED] = expired;
    return s;
  endfunction

endpackage

// File: rtl/fall_timer_if.sv
// rtl/fall_timer_if.sv - instruction bus / read-back bundle of fall_timer
//
// Purpose: groups the sequencer instruction strobe and the timer read-back.
// Signals: inst[11:0]  instruction word (opcode [11:8], immediate [7:0])
//          inst_en     instruction strobe
//          result[7:0] registered read-back value
//          expired     registered sticky expiry flag
interface fall_timer_if;
  logic [11:0] inst;
  logic        inst_en;
  logic [7:0]  result;
  logic        expired;

  modport master (output inst, output inst_en, input result, input expired);
  modport slave  (input inst, input inst_en, output result, output expired);
endinterface

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - 8-bit reloadable prescaler down-counter
//
// Purpose: divides the clock by (reload_value + 1) while run is high.
// Ports:   clock        peripheral clock
//          reset        asynchronous active-low reset
//          load         force counter to load_value (wins over counting)
//          load_value   value taken on load
//          reload_value value taken after the counter reaches zero
//          run          count enable
//          tick         one-cycle pulse on the cycle the counter wraps
module timer_prescaler (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_value,
  input  logic [7:0] reload_value,
  input  logic       run,
  output logic       tick
);

  logic [7:0] cnt;

  // A load in the wrap cycle discards that tick.
  assign tick = run && !load && (cnt == 8'd0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= 8'd0;
    end else if (load) begin
      cnt <= load_value;
    end else if (run) begin
      if (cnt == 8'd0) cnt <= reload_value;
      else             cnt <= cnt - 8'd1;
    end
  end

endmodule

// File: rtl/fall_timer.sv
// rtl/fall_timer.sv - programmable interval timer on the sequencer instruction bus
//
// Purpose: decodes 12-bit timer instructions, runs a prescaled period
//          counter and reports a sticky expiry flag plus a read-back byte.
// Ports:   clock  peripheral clock
//          reset  asynchronous active-low reset
//          bus    fall_timer_if.slave (inst, inst_en in; result, expired out)
module fall_timer
  import fall_timer_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  fall_timer_if.slave  bus
);

  logic [3:0] op;
  logic [7:0] imm;
  logic       is_ldq, is_ldp, is_ldc, is_start, is_stop, is_ack, is_rdc, is_rds, is_bad;

  logic [7:0] presc_rl;
  logic [7:0] period_rl;
  logic [7:0] count;
  logic       running;
  logic       expired_q;
  logic       overrun;
  logic       badop;
  logic       rsel;
  logic [7:0] result_q;

  logic       presc_load;
  logic [7:0] presc_load_value;
  logic       presc_run;
  logic       tick;
  logic       expiry;

  assign op  = bus.inst[11:8];
  assign imm = bus.inst[7:0];

  always_comb begin
    is_ldq   = 1'b0;
    is_ldp   = 1'b0;
    is_ldc   = 1'b0;
    is_start = 1'b0;
    is_stop  = 1'b0;
    is_ack   = 1'b0;
    is_rdc   = 1'b0;
    is_rds   = 1'b0;
    is_bad   = 1'b0;
    if (bus.inst_en) begin
      case (op)
        OP_NOP:   ;
        OP_LDQ:   is_ldq   = 1'b1;
        OP_LDP:   is_ldp   = 1'b1;
        OP_LDC:   is_ldc   = 1'b1;
        OP_START: is_start = 1'b1;
        OP_STOP:  is_stop  = 1'b1;
        OP_ACK:   is_ack   = 1'b1;
        OP_RDC:   is_rdc   = 1'b1;
        OP_RDS:   is_rds   = 1'b1;
        default:  is_bad   = 1'b1;
      endcase
    end
  end

  // LDQ loads the immediate; START restarts from the stored reload value.
  assign presc_load       = is_ldq || is_start;
  assign presc_load_value = is_ldq ? imm : presc_rl;
  // A STOP in the tick cycle must discard the tick, so gate run here.
  assign presc_run        = running && !is_stop;

  timer_prescaler u_prescaler (
    .clock        (clock),
    .reset        (reset),
    .load         (presc_load),
    .load_value   (presc_load_value),
    .reload_value (presc_rl),
    .run          (presc_run),
    .tick         (tick)
  );

  // An LDC in the tick cycle replaces the tick's effect on count.
  assign expiry = tick && !is_ldc && (count == 8'd0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc_rl  <= 8'd0;
      period_rl <= 8'd0;
      count     <= 8'd0;
      running   <= 1'b0;
      expired_q <= 1'b0;
      overrun   <= 1'b0;
      badop     <= 1'b0;
      rsel      <= RSEL_COUNT;
      result_q  <= 8'd0;
    end else begin
      if (is_ldq) presc_rl  <= imm;
      if (is_ldp) period_rl <= imm;

      if (is_ldc) begin
        count <= imm;
      end else if (tick) begin
        if (count == 8'd0) count <= period_rl;
        else               count <= count - 8'd1;
      end

      if (is_start)     running <= 1'b1;
      else if (is_stop) running <= 1'b0;

      // Expiry beats a same-cycle ACK for expired; ACK still clears overrun.
      if (expiry)      expired_q <= 1'b1;
      else if (is_ack) expired_q <= 1'b0;

      if (is_ack)                     overrun <= 1'b0;
      else if (expiry && expired_q)   overrun <= 1'b1;

      if (is_bad) badop <= 1'b1;

      if (is_rdc)      rsel <= RSEL_COUNT;
      else if (is_rds) rsel <= RSEL_STATUS;

      // Read-back samples the live state, so it trails any change by a cycle.
      result_q <= (rsel == RSEL_STATUS) ? status_byte(badop, overrun, running, expired_q)
                                        : count;
    end
  end

  assign bus.result  = result_q;
  assign bus.expired = expired_q;

endmodule

// File: tb/tb_fall_timer.sv
// tb/tb_fall_timer.sv - self-checking bench for fall_timer
module tb_fall_timer;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_bad;
  bit   chk_en;

  fall_timer_if bus ();

  fall_timer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model state
  int   m_qrl, m_qcnt, m_prl, m_count;
  bit   m_run, m_exp, m_over, m_bad, m_status_sel;
  logic [7:0] m_res;

  task automatic model_reset();
    m_qrl = 0; m_qcnt = 0; m_prl = 0; m_count = 0;
    m_run = 0; m_exp = 0; m_over = 0; m_bad = 0; m_status_sel = 0;
    m_res = 8'h00;
  endtask

  function automatic logic [7:0] model_view();
    if (m_status_sel) return {4'b0, m_bad, m_over, m_run, m_exp};
    return m_count[7:0];
  endfunction

  // One clock of the timer as described: prescaler, period counter,
  // then the instruction, with the documented tie-break rules.
  task automatic model_step(input bit en, input int op, input int imm);
    bit tick, expire, ack, was_exp;
    m_res   = model_view();
    tick    = 0;
    expire  = 0;
    ack     = en && op == 6;
    was_exp = m_exp;
    if (m_run && !(en && (op == 1 || op == 4 || op == 5))) begin
      if (m_qcnt > 0) m_qcnt = m_qcnt - 1;
      else begin tick = 1; m_qcnt = m_qrl; end
    end
    if (tick && !(en && op == 3)) begin
      if (m_count > 0) m_count = m_count - 1;
      else begin expire = 1; m_count = m_prl; end
    end
    if (en) begin
      case (op)
        1: begin m_qrl = imm; m_qcnt = imm; end
        2: m_prl = imm;
        3: m_count = imm;
        4: begin m_run = 1; m_qcnt = m_qrl; end
        5: m_run = 0;
        6: ;
        7: m_status_sel = 0;
        8: m_status_sel = 1;
        0: ;
        default: m_bad = 1;
      endcase
    end
    if (ack) begin m_exp = 0; m_over = 0; end
    if (expire) begin
      if (was_exp && !ack) m_over = 1;
      m_exp = 1;
    end
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one instruction slot: inputs change at the falling edge, the DUT
  // samples at the rising edge, and the task returns at the next falling edge.
  task automatic cyc(input bit en, input int op, input int imm);
    bus.inst_en = en;
    bus.inst    = {op[3:0], imm[7:0]};
    @(posedge clock);
    if (!reset) model_reset();
    else        model_step(en, op, imm);
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 0);
  endtask

  always @(negedge clock) begin
    if (chk_en && reset) begin
      check("result", bus.result, m_res);
      check("expired", {7'b0, bus.expired}, {7'b0, m_exp});
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    chk_en = 0;
    reset = 1'b0;
    bus.inst_en = 1'b0;
    bus.inst = 12'h000;
    model_reset();
    @(negedge clock);

    // Reset held with a busy instruction bus
    for (int i = 0; i < 6; i++) cyc(i[0], 4 - (i % 3), 8'h10 + i);
    check("rst_result", bus.result, 8'h00);
    check("rst_expired", {7'b0, bus.expired}, 8'h00);
    reset = 1'b1;
    chk_en = 1;

    // No START: nothing may count
    idle(50);
    cyc(1, 8, 0); idle(1);
    check("idle_status", bus.result, 8'h00);
    cyc(1, 7, 0);

    // Q=1, P=2, count=2: expiry every 6 clocks
    cyc(1, 1, 1); cyc(1, 2, 2); cyc(1, 3, 2); cyc(1, 7, 0);
    cyc(1, 4, 0);
    idle(5);
    check("exp_before6", {7'b0, bus.expired}, 8'h00);
    check("count_at5", bus.result, 8'h00);
    idle(1);
    check("exp_at6", {7'b0, bus.expired}, 8'h01);
    idle(1);
    check("count_reload", bus.result, 8'h02);
    idle(5);
    cyc(1, 8, 0);
    cyc(1, 6, 0);
    check("status_overrun", bus.result, 8'h07);
    idle(1);
    check("status_after_ack", bus.result, 8'h02);
    check("exp_after_ack", {7'b0, bus.expired}, 8'h00);

    // ACK exactly in the expiry cycle
    idle(2);
    cyc(1, 6, 0);
    check("ack_vs_expiry", {7'b0, bus.expired}, 8'h01);
    idle(1);
    check("ack_vs_expiry_st", bus.result, 8'h03);

    cyc(1, 5, 0); cyc(1, 6, 0); idle(1);
    check("stopped_status", bus.result, 8'h00);

    // Illegal opcode
    cyc(1, 12, 8'hFF); idle(1);
    check("badop_status", bus.result, 8'h08);

    // STOP with count=5, hold, resume
    cyc(1, 1, 3); cyc(1, 2, 7); cyc(1, 3, 7); cyc(1, 7, 0);
    cyc(1, 4, 0);
    idle(8);
    cyc(1, 5, 0);
    idle(20);
    check("stop_hold", bus.result, 8'h05);
    cyc(1, 4, 0);
    idle(23);
    check("resume_before", {7'b0, bus.expired}, 8'h00);
    idle(1);
    check("resume_expiry", {7'b0, bus.expired}, 8'h01);

    // Asynchronous reset mid-run
    idle(7);
    #2 reset = 1'b0;
    model_reset();
    #1;
    check("async_rst_result", bus.result, 8'h00);
    check("async_rst_expired", {7'b0, bus.expired}, 8'h00);
    @(negedge clock);
    for (int i = 0; i < 3; i++) cyc(1, 4, i);
    reset = 1'b1;
    idle(20);
    cyc(1, 8, 0); idle(1);
    check("post_rst_status", bus.result, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
